// File: rtl/mfcc_ceps_reader.sv
// Ping-pong capture of indexed DCT coefficient writes at the MFCC pipeline tail.
// Each committed frame leaves on a valid/ready stream as a sequence-number header plus NUM_CEPS words.
module mfcc_ceps_reader #(
    parameter int NUM_CEPS   = 12,
    parameter int CEPS_WIDTH = 16,
    parameter int PTR_WIDTH  = $clog2(NUM_CEPS),
    parameter int DROP_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dct_valid_i,
    input  logic [PTR_WIDTH-1:0]  ceps_ptr_i,
    input  logic [CEPS_WIDTH-1:0] ceps_sample_i,
    input  logic                  dct_done_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [CEPS_WIDTH-1:0] m_data_o,
    output logic                  m_first_o,
    output logic                  m_last_o,
    output logic [CEPS_WIDTH-1:0] frame_count_o,
    output logic [DROP_WIDTH-1:0] drop_count_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL} bank_state_e;
    typedef enum logic [1:0] {RD_IDLE, RD_HEADER, RD_DATA} rd_state_e;

    localparam logic [PTR_WIDTH:0]   NUM_CEPS_W = (PTR_WIDTH + 1)'(NUM_CEPS);
    localparam logic [PTR_WIDTH-1:0] LAST_IDX   = PTR_WIDTH'(NUM_CEPS - 1);

    // Coefficient storage and per-bank bookkeeping
    logic [CEPS_WIDTH-1:0] mem_q [2][NUM_CEPS];
    logic [CEPS_WIDTH-1:0] seq_q [2];
    logic [CEPS_WIDTH-1:0] seq_d [2];
    bank_state_e           bank_q [2];
    bank_state_e           bank_d [2];

    // Write-side frame tracking
    logic                  frame_open_q, frame_open_d;
    logic                  discard_q, discard_d;
    logic                  fill_bank_q, fill_bank_d;
    logic [NUM_CEPS-1:0]   mask_q, mask_d;

    // Commit order: ord_q[0] is the oldest FULL bank, ord_cnt_q how many are queued
    logic [1:0]            ord_q, ord_d;
    logic [1:0]            ord_cnt_q, ord_cnt_d;

    // Reader FSM and registered stream outputs
    rd_state_e             rd_state_q, rd_state_d;
    logic [PTR_WIDTH-1:0]  idx_q, idx_d;
    logic [PTR_WIDTH-1:0]  idx_nxt;
    logic                  m_valid_q, m_valid_d;
    logic [CEPS_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_first_q, m_first_d;
    logic                  m_last_q, m_last_d;
    logic [CEPS_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [DROP_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic                  busy_q, busy_d;

    logic                  open_now, frame_active, pick_ok, pick_bank;
    logic                  wr_bank, wr_discard, fill_active, wr_en;
    logic                  commit, drop, hs, pop;
    logic [NUM_CEPS-1:0]   ptr_onehot, mask_now;

    // A frame opening this cycle decides its bank from the pre-edge bank states, so a
    // bank freed by a simultaneous last handshake is only reused by the next frame.
    always_comb begin
        pick_ok   = 1'b1;
        pick_bank = 1'b0;
        if (bank_q[0] != BANK_EMPTY) begin
            pick_bank = 1'b1;
            pick_ok   = (bank_q[1] == BANK_EMPTY);
        end
        open_now     = dct_valid_i && !frame_open_q;
        frame_active = frame_open_q || dct_valid_i;
        wr_bank      = open_now ? pick_bank : fill_bank_q;
        wr_discard   = open_now ? !pick_ok : discard_q;
        fill_active  = frame_active && !wr_discard;
        wr_en        = dct_valid_i && !wr_discard && ({1'b0, ceps_ptr_i} < NUM_CEPS_W);
        ptr_onehot   = '0;
        if (wr_en) begin
            ptr_onehot[ceps_ptr_i] = 1'b1;
        end
        mask_now = (open_now ? '0 : mask_q) | ptr_onehot;
        commit   = dct_done_i && fill_active && (&mask_now);
        drop     = dct_done_i && !commit;
    end

    // A word moves when m_valid_o && m_ready_i. While stalled, data/first/last hold and
    // m_valid_o stays high; it only falls after the handshake of a frame's last word.
    assign hs      = m_valid_q && m_ready_i;
    assign idx_nxt = idx_q + 1'b1;

    always_comb begin
        rd_state_d = rd_state_q;
        idx_d      = idx_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_first_d  = m_first_q;
        m_last_d   = m_last_q;
        pop        = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                if (ord_cnt_q != 2'd0) begin
                    rd_state_d = RD_HEADER;
                    m_valid_d  = 1'b1;
                    m_data_d   = seq_q[ord_q[0]];
                    m_first_d  = 1'b1;
                    m_last_d   = 1'b0;
                end
            end
            RD_HEADER: begin
                if (hs) begin
                    rd_state_d = RD_DATA;
                    idx_d      = '0;
                    m_data_d   = mem_q[ord_q[0]][0];
                    m_first_d  = 1'b0;
                    m_last_d   = (LAST_IDX == '0);
                end
            end
            RD_DATA: begin
                if (hs) begin
                    if (idx_q == LAST_IDX) begin
                        pop = 1'b1;
                        if (ord_cnt_q == 2'd2) begin
                            rd_state_d = RD_HEADER;
                            m_valid_d  = 1'b1;
                            m_data_d   = seq_q[ord_q[1]];
                            m_first_d  = 1'b1;
                            m_last_d   = 1'b0;
                        end else begin
                            rd_state_d = RD_IDLE;
                            m_valid_d  = 1'b0;
                            m_data_d   = '0;
                            m_first_d  = 1'b0;
                            m_last_d   = 1'b0;
                        end
                    end else begin
                        idx_d    = idx_nxt;
                        m_data_d = mem_q[ord_q[0]][idx_nxt];
                        m_last_d = (idx_nxt == LAST_IDX);
                    end
                end
            end
            default: begin
                rd_state_d = RD_IDLE;
                m_valid_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        bank_d       = bank_q;
        seq_d        = seq_q;
        ord_d        = ord_q;
        ord_cnt_d    = ord_cnt_q;
        frame_open_d = frame_open_q;
        discard_d    = discard_q;
        fill_bank_d  = fill_bank_q;
        mask_d       = dct_done_i ? '0 : mask_now;
        frame_cnt_d  = frame_cnt_q;
        drop_cnt_d   = drop_cnt_q;

        if (pop) begin
            bank_d[ord_q[0]] = BANK_EMPTY;
            ord_d[0]         = ord_q[1];
            ord_cnt_d        = ord_cnt_q - 2'd1;
        end
        if (open_now) begin
            frame_open_d = 1'b1;
            discard_d    = !pick_ok;
            if (pick_ok) begin
                fill_bank_d       = pick_bank;
                bank_d[pick_bank] = BANK_FILLING;
            end
        end
        if (dct_done_i) begin
            frame_open_d = 1'b0;
            if (fill_active) begin
                bank_d[wr_bank] = commit ? BANK_FULL : BANK_EMPTY;
            end
        end
        if (commit) begin
            seq_d[wr_bank]         = frame_cnt_q;
            ord_d[ord_cnt_d[0]]    = wr_bank;
            ord_cnt_d              = ord_cnt_d + 2'd1;
            frame_cnt_d            = frame_cnt_q + 1'b1;
        end
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
        busy_d = (ord_cnt_d != 2'd0);
    end

    // Coefficient array carries no reset; a bank is only read once its mask is complete.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_bank][ceps_ptr_i] <= ceps_sample_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                bank_q[b] <= BANK_EMPTY;
                seq_q[b]  <= '0;
            end
            frame_open_q <= 1'b0;
            discard_q    <= 1'b0;
            fill_bank_q  <= 1'b0;
            mask_q       <= '0;
            ord_q        <= '0;
            ord_cnt_q    <= '0;
            rd_state_q   <= RD_IDLE;
            idx_q        <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_first_q    <= 1'b0;
            m_last_q     <= 1'b0;
            frame_cnt_q  <= '0;
            drop_cnt_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                bank_q[b] <= bank_d[b];
                seq_q[b]  <= seq_d[b];
            end
            frame_open_q <= frame_open_d;
            discard_q    <= discard_d;
            fill_bank_q  <= fill_bank_d;
            mask_q       <= mask_d;
            ord_q        <= ord_d;
            ord_cnt_q    <= ord_cnt_d;
            rd_state_q   <= rd_state_d;
            idx_q        <= idx_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_first_q    <= m_first_d;
            m_last_q     <= m_last_d;
            frame_cnt_q  <= frame_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            busy_q       <= busy_d;
        end
    end

    assign m_valid_o     = m_valid_q;
    assign m_data_o      = m_data_q;
    assign m_first_o     = m_first_q;
    assign m_last_o      = m_last_q;
    assign frame_count_o = frame_cnt_q;
    assign drop_count_o  = drop_cnt_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_mfcc_ceps_reader.sv
// Bench for mfcc_ceps_reader: directed scenarios with literal expectations plus randomized
// frames checked every cycle against a frame-level model of banks, counters and stream words.
module tb_mfcc_ceps_reader;

    localparam int NC = 12;
    localparam int CW = 16;
    localparam int PW = 4;
    localparam int DW = 16;
    localparam int W  = CW + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dct_valid_i = 1'b0;
    logic [PW-1:0] ceps_ptr_i = '0;
    logic [CW-1:0] ceps_sample_i = '0;
    logic          dct_done_i = 1'b0;
    logic          m_valid_o;
    logic          m_ready_i = 1'b0;
    logic [CW-1:0] m_data_o;
    logic          m_first_o;
    logic          m_last_o;
    logic [CW-1:0] frame_count_o;
    logic [DW-1:0] drop_count_o;
    logic          busy_o;

    mfcc_ceps_reader #(
        .NUM_CEPS(NC), .CEPS_WIDTH(CW), .PTR_WIDTH(PW), .DROP_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .dct_valid_i(dct_valid_i), .ceps_ptr_i(ceps_ptr_i), .ceps_sample_i(ceps_sample_i),
        .dct_done_i(dct_done_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
        .m_first_o(m_first_o), .m_last_o(m_last_o),
        .frame_count_o(frame_count_o), .drop_count_o(drop_count_o), .busy_o(busy_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;

    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  log_q[$];
    int            log_cyc_q[$];
    int            full_frames = 0;
    bit            open_m = 0;
    bit            fill_m = 0;
    logic [NC-1:0] mask_m = '0;
    logic [CW-1:0] data_m[NC];
    logic [CW-1:0] frame_cnt_m = '0;
    logic [DW-1:0] drop_cnt_m = '0;
    bit            prev_valid = 0;
    bit            prev_ready = 0;
    logic [W-1:0]  prev_word = '0;
    int            last_done_cyc = 0;
    int            ready_mode = 0;

    function automatic logic [W-1:0] mk(input logic f, input logic l, input logic [CW-1:0] d);
        return {f, l, d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare and model advance, once per cycle on the falling edge.
    always @(negedge clk) begin
        logic [W-1:0] cur;
        logic [W-1:0] w;
        bit           hs_last;
        cur     = {m_first_o, m_last_o, m_data_o};
        hs_last = 0;
        if (rst) begin
            exp_q.delete();
            full_frames = 0;
            open_m      = 0;
            fill_m      = 0;
            mask_m      = '0;
            frame_cnt_m = '0;
            drop_cnt_m  = '0;
            prev_valid  = 0;
            prev_ready  = 0;
        end else begin
            check("frame_count", 32'(frame_count_o), 32'(frame_cnt_m));
            check("drop_count", 32'(drop_count_o), 32'(drop_cnt_m));
            check("busy", 32'(busy_o), 32'(full_frames > 0));
            if (prev_valid && !prev_ready) begin
                check("stall_valid", 32'(m_valid_o), 32'd1);
                check("stall_word", 32'(cur), 32'(prev_word));
            end
            if (exp_q.size() == 0) begin
                check("idle_valid", 32'(m_valid_o), 32'd0);
            end else if (m_valid_o) begin
                check("stream_word", 32'(cur), 32'(exp_q[0]));
                if (m_ready_i) begin
                    w = exp_q.pop_front();
                    log_q.push_back(cur);
                    log_cyc_q.push_back(cyc);
                    if (w[CW]) hs_last = 1;
                end
            end

            if (dct_valid_i) begin
                if (!open_m) begin
                    open_m = 1;
                    fill_m = (full_frames < 2);
                    mask_m = '0;
                end
                if (fill_m && int'(ceps_ptr_i) < NC) begin
                    data_m[ceps_ptr_i] = ceps_sample_i;
                    mask_m[ceps_ptr_i] = 1'b1;
                end
            end
            if (dct_done_i) begin
                last_done_cyc = cyc;
                if (open_m && fill_m && (&mask_m)) begin
                    exp_q.push_back(mk(1'b1, 1'b0, frame_cnt_m));
                    for (int i = 0; i < NC; i++) begin
                        exp_q.push_back(mk(1'b0, i == NC - 1, data_m[i]));
                    end
                    frame_cnt_m = frame_cnt_m + 1'b1;
                    full_frames++;
                end else if (drop_cnt_m != '1) begin
                    drop_cnt_m = drop_cnt_m + 1'b1;
                end
                open_m = 0;
                fill_m = 0;
                mask_m = '0;
            end
            if (hs_last) full_frames--;
            prev_valid = m_valid_o;
            prev_ready = m_ready_i;
            prev_word  = cur;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        dct_valid_i = 1'b0;
        dct_done_i  = 1'b0;
        case (ready_mode)
            1: m_ready_i = ~m_ready_i;
            2: m_ready_i = ($urandom_range(0, 9) < 7);
            default: ;
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        log_q.delete();
        log_cyc_q.delete();
    endtask

    task automatic wr(input int ptr, input logic [CW-1:0] val, input bit done);
        dct_valid_i   = 1'b1;
        ceps_ptr_i    = PW'(ptr);
        ceps_sample_i = val;
        dct_done_i    = done;
        tick();
    endtask

    task automatic done_only();
        dct_done_i = 1'b1;
        tick();
    endtask

    task automatic send_frame(input int base);
        for (int i = 0; i < NC; i++) wr(i, CW'(base + i), 1'b0);
        done_only();
    endtask

    task automatic expect_frame(input string name, input int at, input int hdr, input int base);
        if (log_q.size() >= at + NC + 1) begin
            check({name, "_hdr"}, 32'(log_q[at]), 32'(mk(1'b1, 1'b0, CW'(hdr))));
            for (int i = 0; i < NC; i++) begin
                check({name, "_coef"}, 32'(log_q[at + 1 + i]),
                      32'(mk(1'b0, i == NC - 1, CW'(base + i))));
            end
        end else begin
            check({name, "_present"}, 32'(log_q.size()), 32'(at + NC + 1));
        end
    endtask

    task automatic random_frames(input int n);
        int perm[NC];
        int plist[$];
        int kind, j, t, gaps;
        bit merge;
        for (int f = 0; f < n; f++) begin
            kind = $urandom_range(0, 4);
            for (int i = 0; i < NC; i++) perm[i] = i;
            for (int i = NC - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
            plist.delete();
            for (int i = 0; i < NC; i++) plist.push_back(perm[i]);
            if (kind == 1) begin
                for (int r = 0; r < 3; r++)
                    plist.insert($urandom_range(0, plist.size()), $urandom_range(0, NC - 1));
            end else if (kind == 2) begin
                plist.delete($urandom_range(0, plist.size() - 1));
            end else if (kind == 3) begin
                for (int r = 0; r < 2; r++)
                    plist.insert($urandom_range(0, plist.size()), $urandom_range(NC, 15));
            end
            if (kind == 4) begin
                done_only();
            end else begin
                merge = 0;
                for (int i = 0; i < plist.size(); i++) begin
                    merge = (i == plist.size() - 1) && ($urandom_range(0, 1) == 1);
                    wr(plist[i], CW'($urandom), merge);
                    if ($urandom_range(0, 4) == 0) tick();
                end
                if (!merge) done_only();
            end
            gaps = $urandom_range(0, 12);
            repeat (gaps) tick();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  n0;
        bit  found;

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_valid", 32'(m_valid_o), 32'd0);
        check("reset_data", 32'(m_data_o), 32'd0);
        check("reset_busy", 32'(busy_o), 32'd0);

        // Single frame, ready high
        do_reset();
        ready_mode = 0;
        m_ready_i  = 1'b1;
        send_frame(16'h0100);
        repeat (20) tick();
        check("single_words", 32'(log_q.size()), 32'd13);
        expect_frame("single", 0, 0, 16'h0100);
        if (log_cyc_q.size() == 13) begin
            check("single_latency", 32'(log_cyc_q[0] - last_done_cyc), 32'd2);
            check("single_throughput", 32'(log_cyc_q[12] - log_cyc_q[0]), 32'd12);
        end
        check("single_frame_count", 32'(frame_count_o), 32'd1);

        // Backpressure: ready toggles every cycle
        do_reset();
        ready_mode = 1;
        send_frame(16'h0100);
        repeat (40) tick();
        check("bp_words", 32'(log_q.size()), 32'd13);
        expect_frame("bp", 0, 0, 16'h0100);

        // Overflow: three frames while stalled, third is dropped
        do_reset();
        ready_mode = 0;
        m_ready_i  = 1'b0;
        send_frame(16'h1000);
        send_frame(16'h2000);
        send_frame(16'h3000);
        repeat (3) tick();
        check("ovf_frame_count", 32'(frame_count_o), 32'd2);
        check("ovf_drop_count", 32'(drop_count_o), 32'd1);
        check("ovf_hdr_valid", 32'(m_valid_o), 32'd1);
        check("ovf_hdr_first", 32'(m_first_o), 32'd1);
        check("ovf_hdr_data", 32'(m_data_o), 32'd0);
        m_ready_i = 1'b1;
        repeat (35) tick();
        check("ovf_words", 32'(log_q.size()), 32'd26);
        expect_frame("ovf_a", 0, 0, 16'h1000);
        expect_frame("ovf_b", 13, 1, 16'h2000);
        if (log_cyc_q.size() == 26)
            check("ovf_no_bubble", 32'(log_cyc_q[25] - log_cyc_q[0]), 32'd25);

        // Incomplete frame with out-of-range pointers
        do_reset();
        m_ready_i = 1'b1;
        for (int i = 0; i < 11; i++) wr(i, CW'(16'h0500 + i), 1'b0);
        for (int i = 12; i < 16; i++) wr(i, CW'(16'h0600 + i), 1'b0);
        done_only();
        repeat (5) tick();
        check("inc_drop_count", 32'(drop_count_o), 32'd1);
        check("inc_frame_count", 32'(frame_count_o), 32'd0);
        check("inc_no_words", 32'(log_q.size()), 32'd0);
        send_frame(16'h0100);
        repeat (20) tick();
        expect_frame("inc_next", 0, 0, 16'h0100);

        // Last write and done in the same cycle
        do_reset();
        for (int i = 0; i < NC - 1; i++) wr(i, CW'(i), 1'b0);
        wr(NC - 1, CW'(NC - 1), 1'b1);
        repeat (20) tick();
        expect_frame("simul", 0, 0, 16'h0000);
        if (log_q.size() == 13) check("simul_last", 32'(log_q[12]), 32'(mk(1'b0, 1'b1, 16'h000B)));

        // Reset during DATA beat 5
        do_reset();
        send_frame(16'h0100);
        found = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            if (m_valid_o && !m_first_o && m_data_o == 16'h0105) found = 1;
            else tick();
        end
        check("rst_beat5_seen", 32'(found), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_valid", 32'(m_valid_o), 32'd0);
        check("rst_frame_count", 32'(frame_count_o), 32'd0);
        check("rst_drop_count", 32'(drop_count_o), 32'd0);
        log_q.delete();
        log_cyc_q.delete();
        send_frame(16'h0200);
        repeat (20) tick();
        expect_frame("rst_next", 0, 0, 16'h0200);

        // Randomized frames with random backpressure
        do_reset();
        ready_mode = 2;
        random_frames(40);
        ready_mode = 0;
        m_ready_i  = 1'b1;
        n0 = 0;
        while ((exp_q.size() != 0) && n0 < 3000) begin
            tick();
            n0++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (3) tick();
        check("drain_valid", 32'(m_valid_o), 32'd0);
        check("drain_busy", 32'(busy_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mfcc_ceps_reader.md
# mfcc_ceps_reader

Consumer end of the DCT coefficient write port inside the MFCC pipeline. Captures the indexed cepstral writes (`dct_valid` / `ceps_ptr` / `ceps_sample`) and, on each `dct_done`, commits the frame to one of two ping-pong banks. A reader FSM streams each committed frame out over a valid/ready interface as one header word followed by NUM_CEPS coefficient words. It replaces the bare coefficient register array at the pipeline tail.

## Interface
Parameters:
- NUM_CEPS, 12, coefficients per frame
- CEPS_WIDTH, 16, coefficient and stream word width
- PTR_WIDTH, $clog2(NUM_CEPS), write index width
- DROP_WIDTH, 16, drop counter width

Ports:
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- dct_valid_i  in  1  coefficient write strobe
- ceps_ptr_i  in  PTR_WIDTH  coefficient index
- ceps_sample_i  in  CEPS_WIDTH  coefficient value
- dct_done_i  in  1  end-of-frame pulse
- m_valid_o  out  1  stream word valid
- m_ready_i  in  1  downstream ready
- m_data_o  out  CEPS_WIDTH  stream word
- m_first_o  out  1  word is frame header
- m_last_o  out  1  word is last coefficient
- frame_count_o  out  CEPS_WIDTH  frames committed since reset
- drop_count_o  out  DROP_WIDTH  frames discarded, saturating
- busy_o  out  1  any bank FULL or streaming

## Operation
- Two banks of NUM_CEPS x CEPS_WIDTH, each with state EMPTY / FILLING / FULL, plus a NUM_CEPS-bit written-mask for the fill bank.
- Frame opens on the first `dct_valid_i` after reset or after the previous `dct_done_i`. At open:
  - if a bank is EMPTY, it becomes the fill bank (FILLING), lowest index preferred;
  - otherwise the frame is in discard mode.
- A bank that frees mid-frame is not used until the next frame opens.
- Write: `ceps_ptr_i` < NUM_CEPS stores the sample and sets the mask bit. Ptr >= NUM_CEPS is ignored. A repeated ptr overwrites (last write wins). Writes in discard mode are ignored.
- `dct_done_i`:
  - fill bank with all mask bits set -> FULL, queued behind any older FULL bank (strict commit order); frame_count increments; its header value is the pre-increment frame_count.
  - incomplete mask, discard mode, or no writes since the last done -> bank returns to EMPTY, nothing streamed, drop_count += 1 (saturates at all-ones).
- `dct_valid_i` and `dct_done_i` in the same cycle: the write is applied first and counts toward that frame.
- Reader FSM:
  - IDLE -> HEADER when the oldest bank is FULL. HEADER presents m_data = stored sequence number, m_first = 1.
  - HEADER -> DATA on handshake. DATA presents coefficients 0..NUM_CEPS-1 in order; m_last = 1 on index NUM_CEPS-1.
  - On the last handshake the bank goes EMPTY. FSM moves to HEADER of the next FULL bank in the same edge (no bubble), else to IDLE.
- Handshake: a word transfers when m_valid & m_ready. While m_valid = 1 and m_ready = 0, m_data / m_first / m_last are held stable. m_valid never drops without a handshake.

## Timing
- All outputs registered.
- Reset values: m_valid 0, m_data 0, m_first 0, m_last 0, frame_count 0, drop_count 0, busy 0. Both banks EMPTY, masks clear, FSM IDLE, no frame open.
- Reset asserted mid-fill or mid-stream: state clears on that edge; the partial frame is lost without a drop count; m_valid is 0 in the following cycle.
- Latency: with `dct_done_i` completing a frame at cycle T and the reader IDLE, the bank is FULL at T+1 and the header is valid at T+2.
- Throughput with m_ready held high: one word per cycle, NUM_CEPS+1 cycles per frame, consecutive FULL frames back-to-back.
- frame_count and drop_count update on the edge after `dct_done_i`. busy is 1 from that edge until the last handshake leaves no bank FULL.

## Test plan
- Single frame: ptr 0..11 with values 0x0100+i, done, m_ready = 1 -> header 0x0000 at T+2 with m_first; 0x0100..0x010B on the next 12 cycles; m_last with 0x010B; frame_count = 1.
- Backpressure: same frame, m_ready toggling 1/0 each cycle -> every word held stable while stalled, 13 words total, in order, none lost or duplicated.
- Overflow: m_ready = 0, three complete frames (A=0x1000+i, B=0x2000+i, C=0x3000+i) -> frame_count = 2, drop_count = 1. Releasing m_ready streams header 0 + A, then header 1 + B with no bubble; C is never output.
- Incomplete/out-of-range: ptr 0..10 plus ptr 12..15, then done -> drop_count = 1, m_valid stays 0. The next complete frame gets header 0x0000.
- Simultaneous: ptr 0..10 written, then ptr 11 with done in the same cycle -> frame accepted; 0x000B appears as the last word.
- Reset mid-stream: rst for one cycle during DATA beat 5 -> m_valid = 0 next cycle, both counters 0. A following frame streams with header 0x0000.
